rr_arbiter_4: RTL and testbench

- Four-requester round-robin arbiter sharing one resource, using the same d0..d3 priority-encode function as the team's 4-input encoder.
- Registers a one-hot grant and a 2-bit encoded grant ID plus valid, matching the encoder's a/b/v output convention.
- Holds the grant until the owner drops its request, then rotates priority past the last owner.
- Sits between the request sources and the shared datapath, which is selected by gnt_id.

---
 rtl/rr_arbiter_4.sv | 69 ++++++
 tb/tb_rr_arbiter_4.sv | 121 ++++++++++++
 2 files changed

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: four-requester round-robin arbiter with registered one-hot grant, encoded id and valid.
// Optional hold limit with timeout revoke when HOLD_TIMEOUT_EN is defined.
module rr_arbiter_4 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_nx;
  logic [1:0] last, off, winner;
  logic [3:0] elig, rot;
  logic found, revoke;
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_chk
    $error("MAX_HOLD out of range");
  end
  // last doubles as the owner index while a grant is held
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      last  <= 2'd3;
    end else begin
      state <= state_nx;
      if (state == IDLE && found) last <= winner;
    end
  always_comb begin
    rot = 4'b0;
    for (int i = 0; i < 4; i++) rot[i] = elig[last + 2'(i) + 2'd1];
    off    = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
    found  = |elig;
    winner = last + 2'd1 + off;
  end
  always_comb
    state_nx = (state == IDLE) ? (found ? GRANT : IDLE)
             : ((!req[last] || revoke) ? IDLE : GRANT);
  always_comb begin
    gnt       = (state == GRANT) ? 4'b0001 << last : 4'b0000;
    gnt_id    = (state == GRANT) ? last : 2'b00;
    gnt_valid = state == GRANT;
  end
`ifdef HOLD_TIMEOUT_EN
  logic [7:0] hold;
  logic [3:0] mask;
  logic       timeout_q;
  assign revoke  = req[last] && hold == 8'(MAX_HOLD);
  assign elig    = req & ~mask;
  assign timeout = timeout_q;
  // a revoked owner stays masked until its request is seen low
  always_ff @(posedge clk)
    if (rst) begin
      hold      <= 8'd0;
      mask      <= 4'b0;
      timeout_q <= 1'b0;
    end else begin
      hold      <= (state == IDLE) ? (found ? 8'd1 : hold) : (hold == 8'hff ? hold : hold + 8'd1);
      timeout_q <= state == GRANT && revoke;
      mask      <= (mask & req) | ((state == GRANT && revoke) ? gnt : 4'b0000);
    end
`else
  assign revoke  = 1'b0;
  assign elig    = req;
  assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_rr_arbiter_4.sv
// tb_rr_arbiter_4: table-driven scoreboard bench for rr_arbiter_4 (timeout sequence when HOLD_TIMEOUT_EN is defined).
module tb_rr_arbiter_4;
`ifdef HOLD_TIMEOUT_EN
  localparam int MH = 4;
`else
  localparam int MH = 16;
`endif
  typedef struct {
    logic       r;
    logic [3:0] q;
    logic [3:0] g;
    logic [1:0] id;
    logic       v;
    logic       t;
  } vec_t;
  logic clk = 0, rst = 1;
  logic [3:0] req = 4'b0;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic gnt_valid, timeout;
  int checks = 0, failures = 0, n = 0;
  vec_t tbl[$];
  vec_t exp_q[$];
  rr_arbiter_4 #(.MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt),
    .gnt_id(gnt_id), .gnt_valid(gnt_valid), .timeout(timeout)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(input logic r, input logic [3:0] q, input logic [3:0] g,
                              input logic [1:0] id, input logic v, input logic t);
    vec_t x;
    x.r = r; x.q = q; x.g = g; x.id = id; x.v = v; x.t = t;
    return x;
  endfunction
  task automatic step(input vec_t x);
    vec_t e;
    @(negedge clk);
    rst = x.r;
    req = x.q;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    n++;
    checks++;
    if (gnt !== e.g || gnt_id !== e.id || gnt_valid !== e.v || timeout !== e.t) begin
      failures++;
      $display("FAIL step%0d req=%b: got gnt=%b id=%b v=%b to=%b, want gnt=%b id=%b v=%b to=%b",
               n, e.q, gnt, gnt_id, gnt_valid, timeout, e.g, e.id, e.v, e.t);
    end
  endtask
  initial begin
    // reset with all requesting, then round robin 0,1,2,3,0 with gaps
    tbl.push_back(mk(1, 4'b1111, 4'b0000, 2'd0, 0, 0));
    tbl.push_back(mk(1, 4'b1111, 4'b0000, 2'd0, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b0001, 2'd0, 1, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b0001, 2'd0, 1, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b0001, 2'd0, 1, 0));
    tbl.push_back(mk(0, 4'b1110, 4'b0000, 2'd0, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b0010, 2'd1, 1, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b0010, 2'd1, 1, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b0010, 2'd1, 1, 0));
    tbl.push_back(mk(0, 4'b1101, 4'b0000, 2'd0, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b0100, 2'd2, 1, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b0100, 2'd2, 1, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b0100, 2'd2, 1, 0));
    tbl.push_back(mk(0, 4'b1011, 4'b0000, 2'd0, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b1000, 2'd3, 1, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b1000, 2'd3, 1, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b1000, 2'd3, 1, 0));
    tbl.push_back(mk(0, 4'b0111, 4'b0000, 2'd0, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b0001, 2'd0, 1, 0));
    tbl.push_back(mk(0, 4'b1110, 4'b0000, 2'd0, 0, 0));
    // single request, then idle stays idle
    tbl.push_back(mk(0, 4'b0100, 4'b0100, 2'd2, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 2'd0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 2'd0, 0, 0));
    // priority rotation: after owner 1, search starts at 2 and wraps to 0
    tbl.push_back(mk(0, 4'b0010, 4'b0010, 2'd1, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 2'd0, 0, 0));
    tbl.push_back(mk(0, 4'b0011, 4'b0001, 2'd0, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 2'd0, 0, 0));
    // release and new request together: gap cycle first
    tbl.push_back(mk(0, 4'b1000, 4'b1000, 2'd3, 1, 0));
    tbl.push_back(mk(0, 4'b0100, 4'b0000, 2'd0, 0, 0));
    tbl.push_back(mk(0, 4'b0100, 4'b0100, 2'd2, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 2'd0, 0, 0));
    // reset mid-grant on owner 3
    tbl.push_back(mk(0, 4'b1000, 4'b1000, 2'd3, 1, 0));
    tbl.push_back(mk(0, 4'b1000, 4'b1000, 2'd3, 1, 0));
    tbl.push_back(mk(1, 4'b1000, 4'b0000, 2'd0, 0, 0));
    tbl.push_back(mk(0, 4'b1001, 4'b0001, 2'd0, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 2'd0, 0, 0));
    // re-requester gets lowest priority
    tbl.push_back(mk(0, 4'b0001, 4'b0001, 2'd0, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 2'd0, 0, 0));
    tbl.push_back(mk(0, 4'b0011, 4'b0010, 2'd1, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 2'd0, 0, 0));
    repeat (2) @(posedge clk);
    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);
`ifdef HOLD_TIMEOUT_EN
    // last=1, so owner 0 wins, holds 4 cycles, is revoked, then owner 1 wins
    repeat (4) step(mk(0, 4'b0011, 4'b0001, 2'd0, 1, 0));
    step(mk(0, 4'b0011, 4'b0000, 2'd0, 0, 1));
    step(mk(0, 4'b0011, 4'b0010, 2'd1, 1, 0));
    step(mk(0, 4'b0001, 4'b0000, 2'd0, 0, 0));
    step(mk(0, 4'b0001, 4'b0000, 2'd0, 0, 0));
    step(mk(0, 4'b0000, 4'b0000, 2'd0, 0, 0));
    step(mk(0, 4'b0001, 4'b0001, 2'd0, 1, 0));
    step(mk(0, 4'b0000, 4'b0000, 2'd0, 0, 0));
`else
    // without the hold limit a long grant is never revoked
    repeat (24) step(mk(0, 4'b0011, 4'b0001, 2'd0, 1, 0));
    step(mk(0, 4'b0010, 4'b0000, 2'd0, 0, 0));
    step(mk(0, 4'b0010, 4'b0010, 2'd1, 1, 0));
    step(mk(0, 4'b0000, 4'b0000, 2'd0, 0, 0));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
